// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate sequential multiplier.
// Holds the controller state encoding and the elaboration-time helpers
// that derive the tile geometry from the operand width.
package approx_mult_pkg;

  // Bits per operand digit; one tile multiplies one digit of each operand.
  localparam int TILE_BITS = 4;

  // Controller states of the tile-sequencing FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SGN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Number of 4-bit digits in one operand.
  function automatic int calc_n(input int width);
    return width / TILE_BITS;
  endfunction

  // Number of digit-pair tiles that make up one full product.
  function automatic int calc_t(input int width);
    return (width / TILE_BITS) * (width / TILE_BITS);
  endfunction

  // Legal operand widths: whole digits, from 8 to 32 bits.
  function automatic bit width_legal(input int width);
    return ((width % TILE_BITS) == 0) && (width >= 8) && (width <= 32);
  endfunction

endpackage

// File: rtl/approx_mult_seq_mult4x4.sv
// Unsigned 4x4 tile multiplier; purely combinational.
// Ports:
//   a_i  4-bit unsigned multiplicand digit
//   b_i  4-bit unsigned multiplier digit
//   p_o  8-bit unsigned product
module mult4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  // Full-precision product; 15*15 = 225 always fits in 8 bits.
  assign p_o = {4'd0, a_i} * {4'd0, b_i};

endmodule

// File: rtl/approx_mult_seq.sv
// Multi-cycle signed multiplier that reuses a single 4x4 tile multiplier
// over every digit pair of the operand magnitudes, one tile per cycle.
// In approximate mode, tiles whose digit-index sum is below APX_DROP
// contribute nothing, but still take their cycle so latency is fixed.
// Ports:
//   nvdla_core_clk   clock, rising edge
//   nvdla_core_rstn  synchronous active-low reset
//   in_valid/in_ready, in_a, in_b, in_mode   operand handshake
//   out_valid/out_ready, out_p               result handshake (held until taken)
module approx_mult_seq
  import approx_mult_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int APX_DROP = 1
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int N    = calc_n(WIDTH);
  localparam int T    = calc_t(WIDTH);
  localparam int KW   = $clog2(T);
  localparam int SUMW = KW + 1;
  localparam int PW   = 2 * WIDTH;

  localparam logic [KW-1:0]   N_K    = KW'(N);
  localparam logic [KW-1:0]   LAST_K = KW'(T - 1);
  localparam logic [SUMW-1:0] DROP_K = SUMW'(APX_DROP);

  if (!width_legal(WIDTH) || (APX_DROP < 0) || (APX_DROP > 2 * N - 1)) begin : g_param_err
    $error("approx_mult_seq: illegal WIDTH=%0d / APX_DROP=%0d", WIDTH, APX_DROP);
  end

  // Magnitude of a two's-complement value; the most-negative value maps
  // to 2^(WIDTH-1), which is still representable unsigned in WIDTH bits.
  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH-1]) begin
      r = (~v) + WIDTH'(1'b1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  mag_a_q, mag_a_d;
  logic [WIDTH-1:0]  mag_b_q, mag_b_d;
  logic              sign_q, sign_d;
  logic              mode_q, mode_d;
  logic              out_valid_q, out_valid_d;
  logic [PW-1:0]     out_p_q, out_p_d;

  logic [KW-1:0]     i_s, j_s;
  logic [SUMW-1:0]   sum_s;
  logic [3:0]        nib_a_s, nib_b_s;
  logic [7:0]        tile_p_s;
  logic [PW-1:0]     tile_term_s;
  logic              drop_s;

  // Tile k walks |a| digits fastest: i = k % N, j = k / N.
  assign i_s     = k_q % N_K;
  assign j_s     = k_q / N_K;
  assign sum_s   = SUMW'(i_s) + SUMW'(j_s);
  assign nib_a_s = 4'(mag_a_q >> {i_s, 2'b00});
  assign nib_b_s = 4'(mag_b_q >> {j_s, 2'b00});
  assign drop_s  = mode_q && (sum_s < DROP_K);

  mult4x4 u_tile (
    .a_i (nib_a_s),
    .b_i (nib_b_s),
    .p_o (tile_p_s)
  );

  // Tile weight is 16^(i+j); dropped tiles add zero.
  assign tile_term_s = drop_s ? {PW{1'b0}} : (PW'(tile_p_s) << {sum_s, 2'b00});

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

  // Next-state and datapath update for the tile-sequencing FSM.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    mag_a_d     = mag_a_q;
    mag_b_d     = mag_b_q;
    sign_d      = sign_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mag_a_d = mag_of(in_a);
          mag_b_d = mag_of(in_b);
          sign_d  = in_a[WIDTH-1] ^ in_b[WIDTH-1];
          mode_d  = in_mode;
          acc_d   = {PW{1'b0}};
          k_d     = {KW{1'b0}};
          state_d = ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_d = acc_q + tile_term_s;
        if (k_q == LAST_K) begin
          k_d     = {KW{1'b0}};
          state_d = ST_SGN;
        end else begin
          k_d     = k_q + KW'(1'b1);
          state_d = ST_MUL;
        end
      end
      ST_SGN: begin
        // A zero magnitude stays zero so no lone sign bit can appear.
        if (sign_q && (acc_q != {PW{1'b0}})) begin
          out_p_d = (~acc_q) + PW'(1'b1);
        end else begin
          out_p_d = acc_q;
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q     <= ST_IDLE;
      k_q         <= {KW{1'b0}};
      acc_q       <= {PW{1'b0}};
      mag_a_q     <= {WIDTH{1'b0}};
      mag_b_q     <= {WIDTH{1'b0}};
      sign_q      <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_p_q     <= {PW{1'b0}};
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      mag_a_q     <= mag_a_d;
      mag_b_q     <= mag_b_d;
      sign_q      <= sign_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
    end
  end

endmodule

// File: tb/tb_approx_mult_seq.sv
// Scoreboard bench for approx_mult_seq (WIDTH=8, APX_DROP=1).
module tb_approx_mult_seq;

  localparam int WIDTH = 8;
  localparam int DROP  = 1;
  localparam int LAT   = 6;  // edges from "before accept" to out_valid visible

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;

  int checks;
  int errors;
  int cyc;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  approx_mult_seq #(.WIDTH(WIDTH), .APX_DROP(DROP)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_a            (in_a),
    .in_b            (in_b),
    .in_mode         (in_mode),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_p           (out_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: signed product of magnitudes, minus the weight of any
  // digit pair whose index sum is below DROP when approximating.
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                           input logic m);
    int sa, sb, ma, mb, p;
    sa = $signed(a);
    sb = $signed(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    p  = ma * mb;
    if (m) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          if (i + j < DROP)
            p = p - ((((ma >> (4 * i)) & 15) * ((mb >> (4 * j)) & 15)) << (4 * (i + j)));
    end
    if ((sa < 0) != (sb < 0)) p = -p;
    return 16'(p);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one operand set and return #1 after the accept edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic m,
                       input bit expect_result);
    int waited;
    waited   = 0;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      if (expect_result) begin
        exp_q.push_back(ref_prod(a, b, m));
        exp_cyc_q.push_back(cyc + LAT);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  // Monitor: latency on each rising out_valid, value on each transfer.
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_v) begin
        if (exp_cyc_q.size() > 0) chk("latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        else chk("spurious_valid", 32'(out_valid), 32'd0);
      end
      prev_v = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) chk("product", 32'(out_p), 32'(exp_q.pop_front()));
        else chk("unexpected_result", 32'(out_valid), 32'd0);
      end
    end
  end

  initial begin
    int waited;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Exact case with in_ready busy window.
    issue(8'h7F, 8'h7F, 1'b0, 1'b1);
    for (int e = 0; e < 6; e++) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors.
    issue(8'h80, 8'h80, 1'b0, 1'b1);
    issue(8'h80, 8'h01, 1'b0, 1'b1);
    issue(8'h00, 8'hFF, 1'b0, 1'b1);
    issue(8'h13, 8'h15, 1'b1, 1'b1);
    issue(8'hED, 8'h15, 1'b1, 1'b1);
    issue(8'h0F, 8'h0F, 1'b1, 1'b1);
    issue(8'hFF, 8'h01, 1'b1, 1'b1);

    // Backpressure: result must hold, new requests ignored.
    waited = 0;
    while (!in_ready && waited < 50) begin @(posedge clk); #1; waited++; end
    out_ready = 1'b0;
    issue(8'h80, 8'h01, 1'b0, 1'b1);
    waited = 0;
    while (!out_valid && waited < 20) begin @(posedge clk); #1; waited++; end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    in_a     = 8'h55;
    in_b     = 8'h33;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_out_p", 32'(out_p), 32'h0000FF80);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of MUL discards the operation.
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_p", 32'(out_p), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    rstn = 1'b1;
    issue(8'h03, 8'hFD, 1'b0, 1'b1);

    // Random operands and modes.
    for (int r = 0; r < 60; r++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 200) begin @(posedge clk); #1; waited++; end
    chk("drain", 32'(exp_q.size()), 32'd0);
    chk("drain_latency", 32'(exp_cyc_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
